// File: rtl/sha2_round_seq.sv
// -----------------------------------------------------------------------------
// sha2_round_seq
//   Round sequencer for one SHA-2 compression core. It drives the address of a
//   synchronous K-constant ROM (one-cycle read latency, no enable). It also
//   emits a per-round valid strobe and round index aligned with the ROM's K
//   output, plus a message-word select flag. It handles start / abort / stall
//   and reports block completion.
//
//   The K ROMs the sequencer is meant to drive (sha256_Krom, sha512_Krom) live
//   in this file as well.
//
// Parameters
//   ROUNDS   rounds per block (64 for SHA-256, 80 for SHA-512)
//   ROUND_W  round index width, 2**ROUND_W >= ROUNDS (and >= 5 so 16 fits)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a block (taken only while ready=1)
//   last_block  captured with an accepted start, reported on done_last
//   stall       datapath hold; no round issues while high (ignored in DRAIN)
//   abort       synchronous cancel, beats start
//   ready       1 only in IDLE (combinational from state)
//   busy        1 in RUN or DRAIN
//   round       ROM address, connect to the Krom round input
//   rnd_valid   K from the ROM and rnd_idx are valid this cycle
//   rnd_idx     round number of the K currently out of the ROM
//   w_sel       1 when rnd_valid and rnd_idx < 16 (W from message words)
//   done        one-cycle pulse after the last round's rnd_valid
//   done_last   last_block captured at start, held until the next start
// -----------------------------------------------------------------------------
module sha2_round_seq #(
  parameter int ROUNDS  = 64,
  parameter int ROUND_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               last_block,
  input  logic               stall,
  input  logic               abort,
  output logic               ready,
  output logic               busy,
  output logic [ROUND_W-1:0] round,
  output logic               rnd_valid,
  output logic [ROUND_W-1:0] rnd_idx,
  output logic               w_sel,
  output logic               done,
  output logic               done_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [ROUND_W-1:0] MSG_WORDS  = ROUND_W'(16);

  state_t             state_r, state_s;
  logic [ROUND_W-1:0] round_r, round_s;
  logic               rnd_valid_r, rnd_valid_s;
  logic [ROUND_W-1:0] rnd_idx_r, rnd_idx_s;
  logic               w_sel_r, w_sel_s;
  logic               done_r, done_s;
  logic               done_last_r, done_last_s;

  // Next-state and next-output logic; abort overrides everything in every state.
  always_comb begin
    state_s     = state_r;
    round_s     = round_r;
    rnd_valid_s = 1'b0;
    rnd_idx_s   = rnd_idx_r;
    w_sel_s     = 1'b0;
    done_s      = 1'b0;
    done_last_s = done_last_r;

    if (abort) begin
      state_s = S_IDLE;
      round_s = {ROUND_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          // Round stays at 0 so the ROM already holds K[0] when RUN begins.
          round_s = {ROUND_W{1'b0}};
          if (start) begin
            state_s     = S_RUN;
            done_last_s = last_block;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (!stall) begin
            // The ROM registers K[round] on this same edge, so the index
            // registered alongside it lines up with the K output.
            rnd_valid_s = 1'b1;
            rnd_idx_s   = round_r;
            w_sel_s     = (round_r < MSG_WORDS);
            if (round_r < LAST_ROUND) begin
              round_s = round_r + ROUND_W'(1);
            end else begin
              round_s = {ROUND_W{1'b0}};
              state_s = S_DRAIN;
            end
          end else begin
            // Holding round keeps K[round] in the ROM, so the round is
            // re-issued intact once stall drops.
            round_s = round_r;
          end
        end
        S_DRAIN: begin
          // The final round's valid is on the outputs now; finish the block.
          done_s  = 1'b1;
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
          round_s = {ROUND_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      round_r     <= {ROUND_W{1'b0}};
      rnd_valid_r <= 1'b0;
      rnd_idx_r   <= {ROUND_W{1'b0}};
      w_sel_r     <= 1'b0;
      done_r      <= 1'b0;
      done_last_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      round_r     <= round_s;
      rnd_valid_r <= rnd_valid_s;
      rnd_idx_r   <= rnd_idx_s;
      w_sel_r     <= w_sel_s;
      done_r      <= done_s;
      done_last_r <= done_last_s;
    end
  end

  assign ready     = (state_r == S_IDLE);
  assign busy      = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign round     = round_r;
  assign rnd_valid = rnd_valid_r;
  assign rnd_idx   = rnd_idx_r;
  assign w_sel     = w_sel_r;
  assign done      = done_r;
  assign done_last = done_last_r;

endmodule

// -----------------------------------------------------------------------------
// sha256_Krom
//   SHA-256 round constants, synchronous read with one cycle of latency.
// Ports
//   clk    clock
//   round  round address 0..63
//   k      K[round] registered on the rising edge
// -----------------------------------------------------------------------------
module sha256_Krom (
  input  logic        clk,
  input  logic [5:0]  round,
  output logic [31:0] k
);

  function automatic logic [31:0] k_of(input logic [5:0] idx);
    case (idx)
      6'd0:  k_of = 32'h428a2f98;  6'd1:  k_of = 32'h71374491;
      6'd2:  k_of = 32'hb5c0fbcf;  6'd3:  k_of = 32'he9b5dba5;
      6'd4:  k_of = 32'h3956c25b;  6'd5:  k_of = 32'h59f111f1;
      6'd6:  k_of = 32'h923f82a4;  6'd7:  k_of = 32'hab1c5ed5;
      6'd8:  k_of = 32'hd807aa98;  6'd9:  k_of = 32'h12835b01;
      6'd10: k_of = 32'h243185be;  6'd11: k_of = 32'h550c7dc3;
      6'd12: k_of = 32'h72be5d74;  6'd13: k_of = 32'h80deb1fe;
      6'd14: k_of = 32'h9bdc06a7;  6'd15: k_of = 32'hc19bf174;
      6'd16: k_of = 32'he49b69c1;  6'd17: k_of = 32'hefbe4786;
      6'd18: k_of = 32'h0fc19dc6;  6'd19: k_of = 32'h240ca1cc;
      6'd20: k_of = 32'h2de92c6f;  6'd21: k_of = 32'h4a7484aa;
      6'd22: k_of = 32'h5cb0a9dc;  6'd23: k_of = 32'h76f988da;
      6'd24: k_of = 32'h983e5152;  6'd25: k_of = 32'ha831c66d;
      6'd26: k_of = 32'hb00327c8;  6'd27: k_of = 32'hbf597fc7;
      6'd28: k_of = 32'hc6e00bf3;  6'd29: k_of = 32'hd5a79147;
      6'd30: k_of = 32'h06ca6351;  6'd31: k_of = 32'h14292967;
      6'd32: k_of = 32'h27b70a85;  6'd33: k_of = 32'h2e1b2138;
      6'd34: k_of = 32'h4d2c6dfc;  6'd35: k_of = 32'h53380d13;
      6'd36: k_of = 32'h650a7354;  6'd37: k_of = 32'h766a0abb;
      6'd38: k_of = 32'h81c2c92e;  6'd39: k_of = 32'h92722c85;
      6'd40: k_of = 32'ha2bfe8a1;  6'd41: k_of = 32'ha81a664b;
      6'd42: k_of = 32'hc24b8b70;  6'd43: k_of = 32'hc76c51a3;
      6'd44: k_of = 32'hd192e819;  6'd45: k_of = 32'hd6990624;
      6'd46: k_of = 32'hf40e3585;  6'd47: k_of = 32'h106aa070;
      6'd48: k_of = 32'h19a4c116;  6'd49: k_of = 32'h1e376c08;
      6'd50: k_of = 32'h2748774c;  6'd51: k_of = 32'h34b0bcb5;
      6'd52: k_of = 32'h391c0cb3;  6'd53: k_of = 32'h4ed8aa4a;
      6'd54: k_of = 32'h5b9cca4f;  6'd55: k_of = 32'h682e6ff3;
      6'd56: k_of = 32'h748f82ee;  6'd57: k_of = 32'h78a5636f;
      6'd58: k_of = 32'h84c87814;  6'd59: k_of = 32'h8cc70208;
      6'd60: k_of = 32'h90befffa;  6'd61: k_of = 32'ha4506ceb;
      6'd62: k_of = 32'hbef9a3f7;  6'd63: k_of = 32'hc67178f2;
      default: k_of = 32'h00000000;
    endcase
  endfunction

  // Registered read: K for the address presented before the edge.
  always_ff @(posedge clk) begin
    k <= k_of(round);
  end

endmodule

// -----------------------------------------------------------------------------
// sha512_Krom
//   SHA-512 round constants, synchronous read with one cycle of latency.
// Ports
//   clk    clock
//   round  round address 0..79 (addresses above 79 read as zero)
//   k      K[round] registered on the rising edge
// -----------------------------------------------------------------------------
module sha512_Krom (
  input  logic        clk,
  input  logic [6:0]  round,
  output logic [63:0] k
);

  function automatic logic [63:0] k_of(input logic [6:0] idx);
    case (idx)
      7'd0:  k_of = 64'h428a2f98d728ae22;  7'd1:  k_of = 64'h7137449123ef65cd;
      7'd2:  k_of = 64'hb5c0fbcfec4d3b2f;  7'd3:  k_of = 64'he9b5dba58189dbbc;
      7'd4:  k_of = 64'h3956c25bf348b538;  7'd5:  k_of = 64'h59f111f1b605d019;
      7'd6:  k_of = 64'h923f82a4af194f9b;  7'd7:  k_of = 64'hab1c5ed5da6d8118;
      7'd8:  k_of = 64'hd807aa98a3030242;  7'd9:  k_of = 64'h12835b0145706fbe;
      7'd10: k_of = 64'h243185be4ee4b28c;  7'd11: k_of = 64'h550c7dc3d5ffb4e2;
      7'd12: k_of = 64'h72be5d74f27b896f;  7'd13: k_of = 64'h80deb1fe3b1696b1;
      7'd14: k_of = 64'h9bdc06a725c71235;  7'd15: k_of = 64'hc19bf174cf692694;
      7'd16: k_of = 64'he49b69c19ef14ad2;  7'd17: k_of = 64'hefbe4786384f25e3;
      7'd18: k_of = 64'h0fc19dc68b8cd5b5;  7'd19: k_of = 64'h240ca1cc77ac9c65;
      7'd20: k_of = 64'h2de92c6f592b0275;  7'd21: k_of = 64'h4a7484aa6ea6e483;
      7'd22: k_of = 64'h5cb0a9dcbd41fbd4;  7'd23: k_of = 64'h76f988da831153b5;
      7'd24: k_of = 64'h983e5152ee66dfab;  7'd25: k_of = 64'ha831c66d2db43210;
      7'd26: k_of = 64'hb00327c898fb213f;  7'd27: k_of = 64'hbf597fc7beef0ee4;
      7'd28: k_of = 64'hc6e00bf33da88fc2;  7'd29: k_of = 64'hd5a79147930aa725;
      7'd30: k_of = 64'h06ca6351e003826f;  7'd31: k_of = 64'h142929670a0e6e70;
      7'd32: k_of = 64'h27b70a8546d22ffc;  7'd33: k_of = 64'h2e1b21385c26c926;
      7'd34: k_of = 64'h4d2c6dfc5ac42aed;  7'd35: k_of = 64'h53380d139d95b3df;
      7'd36: k_of = 64'h650a73548baf63de;  7'd37: k_of = 64'h766a0abb3c77b2a8;
      7'd38: k_of = 64'h81c2c92e47edaee6;  7'd39: k_of = 64'h92722c851482353b;
      7'd40: k_of = 64'ha2bfe8a14cf10364;  7'd41: k_of = 64'ha81a664bbc423001;
      7'd42: k_of = 64'hc24b8b70d0f89791;  7'd43: k_of = 64'hc76c51a30654be30;
      7'd44: k_of = 64'hd192e819d6ef5218;  7'd45: k_of = 64'hd69906245565a910;
      7'd46: k_of = 64'hf40e35855771202a;  7'd47: k_of = 64'h106aa07032bbd1b8;
      7'd48: k_of = 64'h19a4c116b8d2d0c8;  7'd49: k_of = 64'h1e376c085141ab53;
      7'd50: k_of = 64'h2748774cdf8eeb99;  7'd51: k_of = 64'h34b0bcb5e19b48a8;
      7'd52: k_of = 64'h391c0cb3c5c95a63;  7'd53: k_of = 64'h4ed8aa4ae3418acb;
      7'd54: k_of = 64'h5b9cca4f7763e373;  7'd55: k_of = 64'h682e6ff3d6b2b8a3;
      7'd56: k_of = 64'h748f82ee5defb2fc;  7'd57: k_of = 64'h78a5636f43172f60;
      7'd58: k_of = 64'h84c87814a1f0ab72;  7'd59: k_of = 64'h8cc702081a6439ec;
      7'd60: k_of = 64'h90befffa23631e28;  7'd61: k_of = 64'ha4506cebde82bde9;
      7'd62: k_of = 64'hbef9a3f7b2c67915;  7'd63: k_of = 64'hc67178f2e372532b;
      7'd64: k_of = 64'hca273eceea26619c;  7'd65: k_of = 64'hd186b8c721c0c207;
      7'd66: k_of = 64'heada7dd6cde0eb1e;  7'd67: k_of = 64'hf57d4f7fee6ed178;
      7'd68: k_of = 64'h06f067aa72176fba;  7'd69: k_of = 64'h0a637dc5a2c898a6;
      7'd70: k_of = 64'h113f9804bef90dae;  7'd71: k_of = 64'h1b710b35131c471b;
      7'd72: k_of = 64'h28db77f523047d84;  7'd73: k_of = 64'h32caab7b40c72493;
      7'd74: k_of = 64'h3c9ebe0a15c9bebc;  7'd75: k_of = 64'h431d67c49c100d4c;
      7'd76: k_of = 64'h4cc5d4becb3e42b6;  7'd77: k_of = 64'h597f299cfc657e2a;
      7'd78: k_of = 64'h5fcb6fab3ad6faec;  7'd79: k_of = 64'h6c44198c4a475817;
      default: k_of = 64'h0000000000000000;
    endcase
  endfunction

  // Registered read: K for the address presented before the edge.
  always_ff @(posedge clk) begin
    k <= k_of(round);
  end

endmodule
